// File: rtl/clock_mgr_drp.sv
// MMCM DRP reconfiguration sequencer: read-modify-write of CLKOUT0 while the MMCM
// is held in reset, lock wait, then readback of CLKOUT0 divide and CLKFBOUT multiply.
module clock_mgr_drp #(
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] div_in,
    input  logic        configure,
    output logic [31:0] div_out,
    output logic [31:0] vco_out,
    output logic        busy,
    output logic        error,
    output logic [6:0]  drp_daddr,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    output logic        drp_den,
    output logic        drp_dwe,
    input  logic        drp_drdy,
    output logic        mmcm_rst,
    input  logic        mmcm_locked
);

    // RST_ON and RST_OFF take no cycle of their own: mmcm_rst is raised on the
    // transition into RD08 and dropped on the transition into LOCK_WAIT.
    typedef enum logic [3:0] {
        IDLE, RST_ON, RD08, WR08, RD09, WR09, RST_OFF, LOCK_WAIT, RB08, RB09, RB14, RB15
    } state_t;

    function automatic logic [31:0] decode(input logic [15:0] reg_a, input logic [15:0] reg_b);
        logic [6:0] sum;
        sum = {1'b0, reg_a[11:6]} + {1'b0, reg_a[5:0]};
        return reg_b[6] ? 32'd1 : {25'd0, sum};
    endfunction

    state_t      state, state_d;
    logic [31:0] cnt, cnt_d;
    logic [15:0] rd_a, rd_a_d;
    logic [31:0] div_tmp, div_tmp_d;
    logic [6:0]  d_q, d_d;
    logic        locked_q;
    logic        rb_pending, rb_pending_d;
    logic [31:0] div_out_d, vco_out_d;
    logic        busy_d, error_d, mmcm_rst_d, den_d, dwe_d;
    logic [6:0]  daddr_d;
    logic [15:0] di_d;

    logic        issue, issue_we;
    logic [6:0]  issue_addr;
    state_t      issue_state;
    logic        drp_wait, cfg_valid;
    logic [5:0]  high, low;
    logic        clk_edge, no_count;
    logic        unused_div;

    assign unused_div = ^div_in[31:8];
    assign cfg_valid  = (div_in[7:0] != 8'd0) && (div_in[7:0] <= 8'd126);

    // Valid divides never exceed 126, so d - d/2 fits in six bits and mod-64 arithmetic is exact.
    assign no_count = (d_q == 7'd1);
    assign high     = no_count ? 6'd1 : d_q[6:1];
    assign low      = no_count ? 6'd1 : (d_q[5:0] - d_q[6:1]);
    assign clk_edge = d_q[0] & ~no_count;

    assign drp_wait = state inside {RD08, WR08, RD09, WR09, RB08, RB09, RB14, RB15};

    always_comb begin
        // NOTE: every next-value gets a default first, so no path through the case infers a latch.
        state_d      = state;
        cnt_d        = cnt;
        rd_a_d       = rd_a;
        div_tmp_d    = div_tmp;
        d_d          = d_q;
        rb_pending_d = rb_pending;
        div_out_d    = div_out;
        vco_out_d    = vco_out;
        busy_d       = busy;
        error_d      = error;
        mmcm_rst_d   = mmcm_rst;
        den_d        = 1'b0;
        dwe_d        = drp_dwe;
        daddr_d      = drp_daddr;
        di_d         = drp_di;
        issue        = 1'b0;
        issue_we     = 1'b0;
        issue_addr   = 7'h00;
        issue_state  = IDLE;

        if (drp_wait && !drp_drdy) begin
            if (cnt == 32'(DRDY_TIMEOUT)) begin
                error_d    = 1'b1;
                mmcm_rst_d = 1'b0;
                busy_d     = 1'b0;
                dwe_d      = 1'b0;
                state_d    = IDLE;
            end else begin
                cnt_d = cnt + 32'd1;
            end
        end

        case (state)
            IDLE: begin
                if (rb_pending) begin
                    rb_pending_d = 1'b0;
                    busy_d       = 1'b1;
                    issue        = 1'b1;
                    issue_state  = RB08;
                    issue_addr   = 7'h08;
                end else if (configure) begin
                    if (cfg_valid) begin
                        error_d     = 1'b0;
                        d_d         = div_in[6:0];
                        busy_d      = 1'b1;
                        mmcm_rst_d  = 1'b1;
                        issue       = 1'b1;
                        issue_state = RD08;
                        issue_addr  = 7'h08;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            RD08: if (drp_drdy) begin
                di_d        = (drp_do & 16'hF000) | {4'h0, high, low};
                issue       = 1'b1;
                issue_state = WR08;
                issue_addr  = 7'h08;
                issue_we    = 1'b1;
            end
            WR08: if (drp_drdy) begin
                issue       = 1'b1;
                issue_state = RD09;
                issue_addr  = 7'h09;
            end
            RD09: if (drp_drdy) begin
                di_d        = (drp_do & 16'hFF3F) | {8'h00, clk_edge, no_count, 6'h00};
                issue       = 1'b1;
                issue_state = WR09;
                issue_addr  = 7'h09;
                issue_we    = 1'b1;
            end
            WR09: if (drp_drdy) begin
                dwe_d      = 1'b0;
                mmcm_rst_d = 1'b0;
                cnt_d      = 32'd1;
                state_d    = LOCK_WAIT;
            end
            LOCK_WAIT: begin
                // A lock seen in the timeout cycle still counts as success.
                if (locked_q || cnt == 32'(LOCK_TIMEOUT)) begin
                    error_d     = error | ~locked_q;
                    issue       = 1'b1;
                    issue_state = RB08;
                    issue_addr  = 7'h08;
                end else begin
                    cnt_d = cnt + 32'd1;
                end
            end
            RB08: if (drp_drdy) begin
                rd_a_d      = drp_do;
                issue       = 1'b1;
                issue_state = RB09;
                issue_addr  = 7'h09;
            end
            RB09: if (drp_drdy) begin
                div_tmp_d   = decode(rd_a, drp_do);
                issue       = 1'b1;
                issue_state = RB14;
                issue_addr  = 7'h14;
            end
            RB14: if (drp_drdy) begin
                rd_a_d      = drp_do;
                issue       = 1'b1;
                issue_state = RB15;
                issue_addr  = 7'h15;
            end
            RB15: if (drp_drdy) begin
                div_out_d = div_tmp;
                vco_out_d = decode(rd_a, drp_do);
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                busy_d     = 1'b0;
                mmcm_rst_d = 1'b0;
                state_d    = IDLE;
            end
        endcase

        if (issue) begin
            state_d = issue_state;
            den_d   = 1'b1;
            dwe_d   = issue_we;
            daddr_d = issue_addr;
            cnt_d   = 32'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            cnt        <= 32'd0;
            rd_a       <= 16'd0;
            div_tmp    <= 32'd0;
            d_q        <= 7'd0;
            locked_q   <= 1'b0;
            rb_pending <= 1'b1;
            div_out    <= 32'd0;
            vco_out    <= 32'd0;
            busy       <= 1'b0;
            error      <= 1'b0;
            mmcm_rst   <= 1'b0;
            drp_den    <= 1'b0;
            drp_dwe    <= 1'b0;
            drp_daddr  <= 7'd0;
            drp_di     <= 16'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state      <= state_d;
            cnt        <= cnt_d;
            rd_a       <= rd_a_d;
            div_tmp    <= div_tmp_d;
            d_q        <= d_d;
            locked_q   <= mmcm_locked;
            rb_pending <= rb_pending_d;
            div_out    <= div_out_d;
            vco_out    <= vco_out_d;
            busy       <= busy_d;
            error      <= error_d;
            mmcm_rst   <= mmcm_rst_d;
            drp_den    <= den_d;
            drp_dwe    <= dwe_d;
            drp_daddr  <= daddr_d;
            drp_di     <= di_d;
        end
    end

endmodule

// File: tb/tb_clock_mgr_drp.sv
// Randomized self-checking bench for clock_mgr_drp with a behavioural DRP/MMCM model
// and an arithmetic reference for field encoding and readback decoding.
`timescale 1ns/1ps
module tb_clock_mgr_drp;
    localparam int DRDY_TO = 64;
    localparam int LOCK_TO = 300;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [31:0] div_in = 32'd0;
    logic        configure = 1'b0;
    logic [31:0] div_out, vco_out;
    logic        busy, error;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_di;
    logic [15:0] drp_do = 16'd0;
    logic        drp_den, drp_dwe;
    logic        drp_drdy = 1'b0;
    logic        mmcm_rst;
    logic        mmcm_locked = 1'b0;

    clock_mgr_drp #(.DRDY_TIMEOUT(DRDY_TO), .LOCK_TIMEOUT(LOCK_TO)) dut (
        .clk(clk), .resetn(resetn), .div_in(div_in), .configure(configure),
        .div_out(div_out), .vco_out(vco_out), .busy(busy), .error(error),
        .drp_daddr(drp_daddr), .drp_di(drp_di), .drp_do(drp_do), .drp_den(drp_den),
        .drp_dwe(drp_dwe), .drp_drdy(drp_drdy), .mmcm_rst(mmcm_rst), .mmcm_locked(mmcm_locked)
    );

    always #5 clk = ~clk;

    typedef struct { logic [6:0] addr; logic we; logic [15:0] data; } acc_t;
    acc_t        log_q[$];
    longint      den_cyc[$];
    logic [15:0] mem [0:127];
    int          n_vec = 0, n_err = 0;
    int          lat_max = 3;
    bit          hold_wr08 = 0, lock_block = 0;
    int          den_count = 0, den_multi = 0, rst_rises = 0;
    longint      cyc = 0;
    bit          pend = 0, den_prev = 0, rst_prev = 0;
    int          lat = 0, lock_dly = 5;
    logic [6:0]  p_addr = 7'd0;
    logic        p_we = 1'b0;
    logic [15:0] p_di = 16'd0;

    // DRP slave and MMCM behaviour, plus bus monitoring, all on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (drp_den) begin
                den_count++;
                den_cyc.push_back(cyc);
                if (den_prev) den_multi++;
            end
            if (mmcm_rst && !rst_prev) rst_rises++;
            den_prev = drp_den;
            rst_prev = mmcm_rst;
            drp_drdy = 1'b0;
            drp_do   = 16'($urandom);
            if (!resetn) begin
                pend = 0;
            end else if (pend && !(hold_wr08 && p_we && p_addr == 7'h08)) begin
                if (lat == 0) begin
                    drp_drdy = 1'b1;
                    pend = 0;
                    if (p_we) begin
                        mem[p_addr] = p_di;
                        log_q.push_back('{p_addr, 1'b1, p_di});
                    end else begin
                        drp_do = mem[p_addr];
                        log_q.push_back('{p_addr, 1'b0, mem[p_addr]});
                    end
                end else begin
                    lat--;
                end
            end
            if (drp_den && resetn) begin
                pend   = 1;
                lat    = $urandom_range(0, lat_max);
                p_addr = drp_daddr;
                p_we   = drp_dwe;
                p_di   = drp_di;
            end
            if (mmcm_rst) begin
                mmcm_locked = 1'b0;
                lock_dly    = $urandom_range(2, 20);
            end else if (lock_block) begin
                mmcm_locked = 1'b0;
            end else if (lock_dly > 0) begin
                lock_dly--;
            end else begin
                mmcm_locked = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    function automatic logic [31:0] ref_decode(input logic [15:0] a, input logic [15:0] b);
        if (b[6]) return 32'd1;
        return 32'((a >> 6) & 16'h3F) + 32'(a & 16'h3F);
    endfunction

    function automatic logic [15:0] ref_field08(input int d);
        if (d == 1) return 16'h0041;
        return 16'((d / 2) * 64 + (d - d / 2));
    endfunction

    function automatic logic [15:0] ref_field09(input int d);
        if (d == 1) return 16'h0040;
        return 16'((d % 2) * 128);
    endfunction

    task automatic pulse_cfg(input logic [31:0] v);
        @(negedge clk);
        div_in    = v;
        configure = 1'b1;
        @(negedge clk);
        configure = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", tag, busy, n);
        end
    endtask

    task automatic check_readback_log(input string tag, input int first);
        logic [6:0] ra [4];
        ra = '{7'h08, 7'h09, 7'h14, 7'h15};
        for (int i = 0; i < 4; i++) begin
            if (first + i < log_q.size()) begin
                n_vec++;
                if ({log_q[first + i].addr, log_q[first + i].we} !== {ra[i], 1'b0}) begin
                    n_err++;
                    $display("FAIL %s_rb%0d: addr=%h we=%b, required addr=%h we=0", tag, i,
                             log_q[first + i].addr, log_q[first + i].we, ra[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
        mem[8] = 16'h1104; mem[9] = 16'h0000; mem[20] = 16'h0286; mem[21] = 16'h0000;
        #2 resetn = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({div_out, vco_out, busy, error, drp_daddr, drp_di, drp_den, drp_dwe, mmcm_rst} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: div=%h vco=%h busy=%b err=%b den=%b rst=%b, required all 0",
                     div_out, vco_out, busy, error, drp_den, mmcm_rst);
        end
        log_q.delete();
        resetn = 1'b1;
        wait_idle("reset");
        n_vec++;
        if (log_q.size() !== 4) begin
            n_err++;
            $display("FAIL reset_nacc: %0d accesses, required 4", log_q.size());
        end
        check_readback_log("reset", 0);
        n_vec++;
        if (div_out !== 32'd8 || vco_out !== 32'd16) begin
            n_err++;
            $display("FAIL reset_values: div=%0d vco=%0d, required div=8 vco=16", div_out, vco_out);
        end
        n_vec++;
        if (rst_rises !== 0 || error !== 1'b0) begin
            n_err++;
            $display("FAIL reset_side: mmcm_rst rises=%0d err=%b, required 0 and 0", rst_rises, error);
        end
    endtask

    task automatic test_configure(input int d, input string tag);
        logic [15:0] old08, old09, exp08, exp09;
        logic [31:0] exp_vco;
        logic [6:0]  ea [8];
        bit          ew [8];
        logic [15:0] ed [8];
        int          rises0;
        old08   = mem[8];
        old09   = mem[9];
        exp08   = (old08 & 16'hF000) | ref_field08(d);
        exp09   = (old09 & 16'hFF3F) | ref_field09(d);
        exp_vco = ref_decode(mem[20], mem[21]);
        ea = '{7'h08, 7'h08, 7'h09, 7'h09, 7'h08, 7'h09, 7'h14, 7'h15};
        ew = '{0, 1, 0, 1, 0, 0, 0, 0};
        ed = '{default: 16'h0};
        ed[1] = exp08;
        ed[3] = exp09;
        log_q.delete();
        den_cyc.delete();
        rises0 = rst_rises;
        pulse_cfg({24'($urandom), 8'(d)});
        n_vec++;
        if ({busy, mmcm_rst, drp_den, drp_dwe, drp_daddr} !== {3'b111, 1'b0, 7'h08}) begin
            n_err++;
            $display("FAIL %s_start: busy=%b rst=%b den=%b dwe=%b addr=%h, required 1 1 1 0 08",
                     tag, busy, mmcm_rst, drp_den, drp_dwe, drp_daddr);
        end
        wait_idle(tag);
        n_vec++;
        if (log_q.size() !== 8) begin
            n_err++;
            $display("FAIL %s_nacc: %0d accesses, required 8", tag, log_q.size());
        end
        for (int i = 0; i < 8; i++) begin
            if (i < log_q.size()) begin
                n_vec++;
                if ({log_q[i].addr, log_q[i].we} !== {ea[i], ew[i]} || (ew[i] && log_q[i].data !== ed[i])) begin
                    n_err++;
                    $display("FAIL %s_acc%0d: addr=%h we=%b data=%h, required addr=%h we=%b data=%h",
                             tag, i, log_q[i].addr, log_q[i].we, log_q[i].data, ea[i], ew[i], ed[i]);
                end
            end
        end
        n_vec++;
        if (div_out !== 32'(d) || vco_out !== exp_vco) begin
            n_err++;
            $display("FAIL %s_result: div=%0d vco=%0d, required div=%0d vco=%0d", tag, div_out, vco_out, d, exp_vco);
        end
        n_vec++;
        if (error !== 1'b0 || mmcm_rst !== 1'b0 || rst_rises !== rises0 + 1) begin
            n_err++;
            $display("FAIL %s_status: err=%b rst=%b rises=%0d, required 0 0 %0d", tag, error, mmcm_rst,
                     rst_rises - rises0, 1);
        end
    endtask

    task automatic test_invalid();
        int vals [3];
        int c0;
        vals = '{0, 127, int'($urandom_range(128, 255))};
        for (int i = 0; i < 3; i++) begin
            c0 = den_count;
            pulse_cfg({24'($urandom), 8'(vals[i])});
            repeat (3) @(negedge clk);
            n_vec++;
            if (error !== 1'b1 || den_count !== c0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL invalid_%0d: err=%b den_pulses=%0d busy=%b, required 1 0 0", vals[i], error,
                         den_count - c0, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        lat_max = 0;
        test_configure(int'($urandom_range(1, 126)), "b2b");
        for (int i = 1; i < 8; i++) begin
            if (i != 4 && i < den_cyc.size()) begin
                n_vec++;
                if (den_cyc[i] - den_cyc[i - 1] !== 64'd2) begin
                    n_err++;
                    $display("FAIL b2b_gap%0d: %0d cycles, required 2", i, den_cyc[i] - den_cyc[i - 1]);
                end
            end
        end
        n_vec++;
        if (den_multi !== 0) begin
            n_err++;
            $display("FAIL den_width: %0d multi-cycle den pulses, required 0", den_multi);
        end
        lat_max = 3;
    endtask

    task automatic test_busy_strobe();
        int d1, d2, rises0, nwr;
        d1 = $urandom_range(1, 126);
        d2 = (d1 % 126) + 1;
        rises0 = rst_rises;
        log_q.delete();
        pulse_cfg({24'd0, 8'(d1)});
        pulse_cfg({24'd0, 8'(d2)});
        repeat (8) @(negedge clk);
        pulse_cfg({24'd0, 8'(d2)});
        wait_idle("busy_strobe");
        nwr = 0;
        foreach (log_q[i]) if (log_q[i].we) nwr++;
        n_vec++;
        if (log_q.size() !== 8 || nwr !== 2 || rst_rises !== rises0 + 1) begin
            n_err++;
            $display("FAIL busy_strobe_seq: %0d accesses %0d writes %0d resets, required 8 2 1",
                     log_q.size(), nwr, rst_rises - rises0);
        end
        n_vec++;
        if (div_out !== 32'(d1)) begin
            n_err++;
            $display("FAIL busy_strobe_div: div=%0d, required %0d", div_out, d1);
        end
    endtask

    task automatic test_drdy_timeout();
        int n, k, c1;
        logic [31:0] div_before;
        div_before = div_out;
        hold_wr08 = 1;
        log_q.delete();
        pulse_cfg({24'd0, 8'($urandom_range(2, 126))});
        n = 0;
        while (!(drp_den === 1'b1 && drp_dwe === 1'b1 && drp_daddr === 7'h08) && n < 100) begin
            @(negedge clk);
            n++;
        end
        k = 0;
        while (error !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (k !== DRDY_TO) begin
            n_err++;
            $display("FAIL drdy_to_latency: error after %0d cycles, required %0d", k, DRDY_TO);
        end
        n_vec++;
        if (mmcm_rst !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL drdy_to_state: rst=%b busy=%b, required 0 0", mmcm_rst, busy);
        end
        c1 = den_count;
        repeat (10) @(negedge clk);
        n_vec++;
        if (den_count !== c1 || log_q.size() !== 1 || div_out !== div_before) begin
            n_err++;
            $display("FAIL drdy_to_norb: extra den=%0d accesses=%0d div=%0d, required 0 1 %0d",
                     den_count - c1, log_q.size(), div_out, div_before);
        end
        #1;
        pend = 0;
        hold_wr08 = 0;
    endtask

    task automatic test_lock_timeout();
        int d, n, k;
        d = $urandom_range(1, 126);
        lock_block = 1;
        log_q.delete();
        pulse_cfg({24'd0, 8'(d)});
        n = 0;
        while (mmcm_rst !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        k = 0;
        while (drp_den !== 1'b1 && k < LOCK_TO + 50) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (k !== LOCK_TO || error !== 1'b1) begin
            n_err++;
            $display("FAIL lock_to: readback after %0d cycles err=%b, required %0d and 1", k, error, LOCK_TO);
        end
        lock_block = 0;
        wait_idle("lock_to");
        n_vec++;
        if (log_q.size() !== 8 || div_out !== 32'(d) || error !== 1'b1) begin
            n_err++;
            $display("FAIL lock_to_rb: accesses=%0d div=%0d err=%b, required 8 %0d 1", log_q.size(), div_out, error, d);
        end
        check_readback_log("lock_to", 4);
    endtask

    task automatic test_reset_mid();
        int n;
        pulse_cfg({24'd0, 8'($urandom_range(1, 126))});
        n = 0;
        while (!(drp_den === 1'b1 && drp_dwe === 1'b1 && drp_daddr === 7'h09) && n < 200) begin
            @(negedge clk);
            n++;
        end
        #2 resetn = 1'b0;
        #1;
        n_vec++;
        if ({div_out, vco_out, busy, error, drp_daddr, drp_di, drp_den, drp_dwe, mmcm_rst} !== '0) begin
            n_err++;
            $display("FAIL midreset_async: div=%h vco=%h busy=%b den=%b rst=%b, required all 0",
                     div_out, vco_out, busy, drp_den, mmcm_rst);
        end
        repeat (3) @(negedge clk);
        log_q.delete();
        resetn = 1'b1;
        wait_idle("midreset");
        n_vec++;
        if (log_q.size() !== 4) begin
            n_err++;
            $display("FAIL midreset_nacc: %0d accesses, required 4", log_q.size());
        end
        check_readback_log("midreset", 0);
        n_vec++;
        if (div_out !== ref_decode(mem[8], mem[9]) || vco_out !== ref_decode(mem[20], mem[21])) begin
            n_err++;
            $display("FAIL midreset_values: div=%0d vco=%0d, required %0d %0d", div_out, vco_out,
                     ref_decode(mem[8], mem[9]), ref_decode(mem[20], mem[21]));
        end
    endtask

    initial begin
        test_reset();
        test_configure(5, "cfg5");
        test_configure(1, "cfg1");
        test_invalid();
        for (int i = 0; i < 6; i++) begin
            mem[8]  = 16'($urandom);
            mem[9]  = 16'($urandom);
            mem[20] = 16'($urandom);
            mem[21] = 16'($urandom);
            test_configure(int'($urandom_range(1, 126)), "cfg_rand");
        end
        test_back_to_back();
        test_busy_strobe();
        test_drdy_timeout();
        test_lock_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
